// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - MIPS main-decoder constants, control bundle layout and interlock states
package decode_pkg;

    localparam int CTRL_W = 17;

    localparam int F_REGWRITE     = 0;
    localparam int F_REGDST       = 1;
    localparam int F_ALUSRC       = 2;
    localparam int F_BRANCH       = 3;
    localparam int F_BAL          = 4;
    localparam int F_JAL          = 5;
    localparam int F_JR           = 6;
    localparam int F_MEMWRITE     = 7;
    localparam int F_MEMTOREG     = 8;
    localparam int F_JUMP         = 9;
    localparam int F_HILOWRITE    = 10;
    localparam int F_HILODST      = 11;
    localparam int F_HILOTOREG    = 12;
    localparam int F_HILOSRC      = 13;
    localparam int F_MULDIV_START = 14;
    localparam int F_MULDIV_DIV   = 15;
    localparam int F_MULDIV_SIGN  = 16;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_LHU    = 6'h25;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    localparam logic [4:0] RT_BLTZ   = 5'h00;
    localparam logic [4:0] RT_BGEZ   = 5'h01;
    localparam logic [4:0] RT_BLTZAL = 5'h10;
    localparam logic [4:0] RT_BGEZAL = 5'h11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Anything that touches HI/LO must wait for an in-flight multiply/divide.
    function automatic logic needs_hilo(input logic [CTRL_W-1:0] ctrl);
        return ctrl[F_HILOTOREG] | ctrl[F_HILOWRITE] | ctrl[F_MULDIV_START];
    endfunction

endpackage

// File: rtl/maindec_pipe_if.sv
// rtl/maindec_pipe_if.sv - instruction-in / control-bundle-out handshake bundle
interface maindec_pipe_if;
    import decode_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [31:0]       out_instr;
    logic              out_ri;

    modport master (
        output in_valid, instr, flush, out_ready,
        input  in_ready, out_valid, out_ctrl, out_instr, out_ri
    );

    modport slave (
        input  in_valid, instr, flush, out_ready,
        output in_ready, out_valid, out_ctrl, out_instr, out_ri
    );
endinterface

// File: rtl/maindec_comb.sv
// rtl/maindec_comb.sv - combinational MIPS main decoder: instruction word to control bundle
module maindec_comb
    import decode_pkg::*;
#(
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic [31:0]       i_instr,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic              o_ri
);

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic [4:0] w_rt;
    logic       w_unused;

    assign w_op     = i_instr[31:26];
    assign w_rt     = i_instr[20:16];
    assign w_funct  = i_instr[5:0];
    assign w_unused = ^{i_instr[25:21], i_instr[15:6]};

    // Everything defaults to zero, so a reserved instruction carries no side effects.
    always_comb begin
        o_ctrl = '0;
        o_ri   = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                case (w_funct)
                    FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                    FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
                        o_ctrl[F_REGWRITE] = 1'b1;
                        o_ctrl[F_REGDST]   = 1'b1;
                    end
                    FN_JR: o_ctrl[F_JR] = 1'b1;
                    FN_JALR: begin
                        o_ctrl[F_JR]       = 1'b1;
                        o_ctrl[F_JAL]      = 1'b1;
                        o_ctrl[F_REGWRITE] = 1'b1;
                        o_ctrl[F_REGDST]   = 1'b1;
                    end
                    FN_MFHI, FN_MFLO: begin
                        o_ctrl[F_REGWRITE]  = 1'b1;
                        o_ctrl[F_REGDST]    = 1'b1;
                        o_ctrl[F_HILOTOREG] = 1'b1;
                        o_ctrl[F_HILOSRC]   = (w_funct == FN_MFHI);
                    end
                    FN_MTHI, FN_MTLO: begin
                        o_ctrl[F_HILOWRITE] = 1'b1;
                        o_ctrl[F_HILODST]   = (w_funct == FN_MTHI);
                    end
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        if (MULDIV_EN) begin
                            o_ctrl[F_MULDIV_START] = 1'b1;
                            o_ctrl[F_HILOWRITE]    = 1'b1;
                            o_ctrl[F_MULDIV_DIV]   = w_funct[1];
                            o_ctrl[F_MULDIV_SIGN]  = ~w_funct[0];
                        end else begin
                            o_ri = 1'b1;
                        end
                    end
                    default: o_ri = 1'b1;
                endcase
            end
            OP_REGIMM: begin
                case (w_rt)
                    RT_BLTZ, RT_BGEZ: o_ctrl[F_BRANCH] = 1'b1;
                    RT_BLTZAL, RT_BGEZAL: begin
                        o_ctrl[F_BRANCH]   = 1'b1;
                        o_ctrl[F_BAL]      = 1'b1;
                        o_ctrl[F_REGWRITE] = 1'b1;
                    end
                    default: o_ri = 1'b1;
                endcase
            end
            OP_J: o_ctrl[F_JUMP] = 1'b1;
            OP_JAL: begin
                o_ctrl[F_JUMP]     = 1'b1;
                o_ctrl[F_JAL]      = 1'b1;
                o_ctrl[F_REGWRITE] = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: o_ctrl[F_BRANCH] = 1'b1;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                o_ctrl[F_REGWRITE] = 1'b1;
                o_ctrl[F_ALUSRC]   = 1'b1;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                o_ctrl[F_REGWRITE] = 1'b1;
                o_ctrl[F_ALUSRC]   = 1'b1;
                o_ctrl[F_MEMTOREG] = 1'b1;
            end
            OP_SB, OP_SH, OP_SW: begin
                o_ctrl[F_MEMWRITE] = 1'b1;
                o_ctrl[F_ALUSRC]   = 1'b1;
            end
            default: o_ri = 1'b1;
        endcase
    end

endmodule

// File: rtl/maindec_pipe.sv
// rtl/maindec_pipe.sv - two-entry decode buffer with HI/LO interlock behind multiply/divide
module maindec_pipe
    import decode_pkg::*;
#(
    parameter int MULT_LAT  = 3,
    parameter int DIV_LAT   = 34,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic          clk,
    input  logic          resetn,
    maindec_pipe_if.slave bus
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;

    logic [CTRL_W-1:0] w_dec_ctrl;
    logic              w_dec_ri;
    logic              w_acc;
    logic              w_xfer;
    logic              w_stall;
    logic              w_s_valid_nxt;
    logic [CNT_W-1:0]  w_lat;

    logic              r_h_valid;
    logic [CTRL_W-1:0] r_h_ctrl;
    logic [31:0]       r_h_instr;
    logic              r_h_ri;
    logic              r_s_valid;
    logic [CTRL_W-1:0] r_s_ctrl;
    logic [31:0]       r_s_instr;
    logic              r_s_ri;
    logic              r_in_ready;
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;

    maindec_comb #(.MULDIV_EN(MULDIV_EN)) u_dec (
        .i_instr (bus.instr),
        .o_ctrl  (w_dec_ctrl),
        .o_ri    (w_dec_ri)
    );

    assign w_stall       = (r_state == ST_BUSY) && needs_hilo(r_h_ctrl);
    assign w_acc         = bus.in_valid && r_in_ready;
    assign w_xfer        = r_h_valid && !w_stall && bus.out_ready;
    assign w_s_valid_nxt = (r_h_valid && !w_xfer) ? (r_s_valid || w_acc) : 1'b0;
    assign w_lat         = r_h_ctrl[F_MULDIV_DIV] ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_h_valid && !w_stall;
    assign bus.out_ctrl  = r_h_ctrl;
    assign bus.out_instr = r_h_instr;
    assign bus.out_ri    = r_h_ri;

    // Head refills from the skid first so order is preserved; new words only enter a free slot.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_h_valid  <= 1'b0;
            r_h_ctrl   <= '0;
            r_h_instr  <= '0;
            r_h_ri     <= 1'b0;
            r_s_valid  <= 1'b0;
            r_s_ctrl   <= '0;
            r_s_instr  <= '0;
            r_s_ri     <= 1'b0;
            r_in_ready <= 1'b1;
        end else if (bus.flush) begin
            r_h_valid  <= 1'b0;
            r_s_valid  <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            if (!r_h_valid || w_xfer) begin
                if (r_s_valid) begin
                    r_h_ctrl  <= r_s_ctrl;
                    r_h_instr <= r_s_instr;
                    r_h_ri    <= r_s_ri;
                end else if (w_acc) begin
                    r_h_ctrl  <= w_dec_ctrl;
                    r_h_instr <= bus.instr;
                    r_h_ri    <= w_dec_ri;
                end
                r_h_valid <= r_s_valid || w_acc;
            end else if (w_acc) begin
                r_s_ctrl  <= w_dec_ctrl;
                r_s_instr <= bus.instr;
                r_s_ri    <= w_dec_ri;
            end
            r_s_valid  <= w_s_valid_nxt;
            r_in_ready <= !w_s_valid_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer && r_h_ctrl[F_MULDIV_START] && (w_lat != '0)) begin
                        r_cnt   <= w_lat;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maindec_pipe.sv
// tb/tb_maindec_pipe.sv - directed self-checking bench for maindec_pipe
module tb_maindec_pipe;
    import decode_pkg::*;

    localparam logic [31:0] I_ADDU   = 32'h00851021;
    localparam logic [31:0] I_LW     = 32'h8C820004;
    localparam logic [31:0] I_SW     = 32'hAC820008;
    localparam logic [31:0] I_DIV    = 32'h0085001A;
    localparam logic [31:0] I_MFLO   = 32'h00001012;
    localparam logic [31:0] I_RI     = 32'hFC000000;
    localparam logic [31:0] I_BNE    = 32'h14850003;
    localparam logic [31:0] I_BGEZAL = 32'h04910010;
    localparam logic [31:0] I_BADRT  = 32'h04850000;
    localparam logic [31:0] I_MTHI   = 32'h00800011;
    localparam logic [31:0] I_MULT   = 32'h00850018;
    localparam logic [31:0] I_A1     = 32'h00A62021;
    localparam logic [31:0] I_A2     = 32'h00C73021;
    localparam logic [31:0] I_A3     = 32'h00E84021;
    localparam logic [31:0] I_A4     = 32'h01094821;
    localparam logic [31:0] I_A5     = 32'h012A5021;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   t0;
    int   stall;

    maindec_pipe_if bus();

    maindec_pipe #(.MULT_LAT(3), .DIV_LAT(34), .MULDIV_EN(1'b1)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] w);
        bus.in_valid = 1'b1;
        bus.instr    = w;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int waited);
        waited = 0;
        while (!bus.out_valid && waited < limit) begin
            waited++;
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.instr     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_ctrl", bus.out_ctrl, 0);
        check("rst_out_instr", bus.out_instr, 0);
        check("rst_out_ri", bus.out_ri, 0);
        resetn        = 1'b1;
        bus.out_ready = 1'b1;

        send(I_ADDU);
        check("addu_valid", bus.out_valid, 1);
        check("addu_instr", bus.out_instr, I_ADDU);
        check("addu_regwrite", bus.out_ctrl[F_REGWRITE], 1);
        check("addu_regdst", bus.out_ctrl[F_REGDST], 1);
        check("addu_alusrc", bus.out_ctrl[F_ALUSRC], 0);
        check("addu_ri", bus.out_ri, 0);
        @(negedge clk);
        check("addu_drained", bus.out_valid, 0);

        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.instr     = I_LW;
        @(negedge clk);
        check("lw_in_ready", bus.in_ready, 1);
        bus.instr = I_SW;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("full_in_ready", bus.in_ready, 0);
        check("lw_head_valid", bus.out_valid, 1);
        check("lw_head_instr", bus.out_instr, I_LW);
        check("lw_memtoreg", bus.out_ctrl[F_MEMTOREG], 1);
        repeat (3) @(negedge clk);
        check("lw_hold_instr", bus.out_instr, I_LW);
        check("lw_hold_ctrl", bus.out_ctrl[F_MEMTOREG], 1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("sw_head_instr", bus.out_instr, I_SW);
        check("sw_memwrite", bus.out_ctrl[F_MEMWRITE], 1);
        check("sw_in_ready", bus.in_ready, 1);
        @(negedge clk);
        check("sw_drained", bus.out_valid, 0);

        send(I_RI);
        check("ri_flag", bus.out_ri, 1);
        check("ri_ctrl_zero", bus.out_ctrl, 0);
        send(I_BNE);
        check("bne_branch", bus.out_ctrl[F_BRANCH], 1);
        check("bne_regwrite", bus.out_ctrl[F_REGWRITE], 0);
        check("bne_ri", bus.out_ri, 0);
        send(I_BGEZAL);
        check("bgezal_ctrl", bus.out_ctrl, 32'h00019);
        send(I_BADRT);
        check("badrt_ri", bus.out_ri, 1);
        send(I_MTHI);
        check("mthi_ctrl", bus.out_ctrl, 32'h00C00);
        send(I_MULT);
        check("mult_ctrl", bus.out_ctrl, 32'h14400);
        repeat (5) @(negedge clk);

        bus.in_valid = 1'b1;
        bus.instr    = I_DIV;
        @(negedge clk);
        bus.instr = I_MFLO;
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_valid(100, stall);
        check("div_mflo_stall", stall, 34);
        check("div_mflo_instr", bus.out_instr, I_MFLO);
        @(negedge clk);

        bus.in_valid = 1'b1;
        bus.instr    = I_DIV;
        @(negedge clk);
        bus.instr = I_ADDU;
        @(negedge clk);
        check("busy_addu_valid", bus.out_valid, 1);
        check("busy_addu_instr", bus.out_instr, I_ADDU);
        bus.instr = I_MFLO;
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_valid(100, stall);
        check("div_addu_mflo_stall", stall, 33);
        check("div_addu_mflo_instr", bus.out_instr, I_MFLO);
        @(negedge clk);

        bus.in_valid = 1'b1;
        bus.instr    = I_DIV;
        @(negedge clk);
        t0        = cyc;
        bus.instr = I_A1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.instr     = I_A2;
        @(negedge clk);
        check("flush_pre_in_ready", bus.in_ready, 0);
        check("flush_pre_valid", bus.out_valid, 1);
        bus.instr = I_A3;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_full_valid", bus.out_valid, 0);
        check("flush_full_in_ready", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.instr    = I_A4;
        @(negedge clk);
        bus.instr = I_A5;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_acc_valid", bus.out_valid, 0);
        check("flush_acc_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        send(I_MFLO);
        wait_valid(100, stall);
        check("flush_busy_kept", cyc - t0, 35);
        check("flush_next_instr", bus.out_instr, I_MFLO);
        @(negedge clk);

        bus.in_valid = 1'b1;
        bus.instr    = I_DIV;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("rst_busy_empty", bus.out_valid, 0);
        send(I_MFLO);
        check("rst_busy_abandon", bus.out_valid, 1);
        check("rst_busy_instr", bus.out_instr, I_MFLO);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
